// File: rtl/ram_fill_drain_ctrl.sv
// ram_fill_drain_ctrl
//   Sequencer in front of a single-port RAM with a registered read address.
//   A valid/ready word stream is written to ascending RAM addresses from 0.
//   When the RAM fills, or on flush, the stored burst is read back in order
//   as a valid/ready stream. The RAM's one-cycle read latency is hidden by
//   an address cycle (RD_ADDR) followed by a capture cycle (RD_CAP).
//
//   Optional feature macro: RFD_REPLAY_EN
//     Adds input 'replay'. In IDLE, after a completed burst, a replay pulse
//     drains the same words again. Incoming s_valid wins over replay, and
//     any newly accepted word discards the saved burst length.
//
//   Ports
//     clk, rst               clock; asynchronous active-low reset
//     s_data/s_valid/s_ready input word stream
//     flush                  end the current burst early and start the drain
//     m_data/m_valid/m_ready drained word stream (m_data/m_valid registered)
//     m_last                 marks the final drained word
//     ram_addr/ram_we/ram_wdata/ram_rdata  RAM pins
//     count                  words currently held (0..DEPTH)
//     busy                   high in any drain state
module ram_fill_drain_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  busy
`ifdef RFD_REPLAY_EN
  ,
  input  logic                  replay
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    RD_ADDR = 3'd2,
    RD_CAP  = 3'd3,
    RD_HOLD = 3'd4
  } state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_n;
  logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_n;
  logic [CW-1:0]         count_q, count_n;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_n;
  logic                  m_valid_q, m_valid_n;
  logic                  m_last_q, m_last_n;
  logic                  fill_phase;
  logic                  accept;
  logic                  last_hit;
  logic                  replay_go;

`ifdef RFD_REPLAY_EN
  logic [CW-1:0]         saved_len, saved_len_n;
  assign replay_go = replay && (saved_len != '0);
`else
  assign replay_go = 1'b0;
`endif

  // Input side is only open while filling; gated by reset so nothing is
  // accepted or written while rst is held low.
  assign fill_phase = (state == IDLE) || (state == FILL);
  assign s_ready    = rst && fill_phase && (count_q < CW'(DEPTH));
  assign accept     = s_valid && s_ready;
  assign ram_we     = accept;
  assign ram_wdata  = s_data;
  assign ram_addr   = fill_phase ? wr_ptr : rd_ptr;
  assign last_hit   = ({1'b0, rd_ptr} == (count_q - CW'(1)));

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign count   = count_q;
  assign busy    = (state == RD_ADDR) || (state == RD_CAP) || (state == RD_HOLD);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
`ifdef RFD_REPLAY_EN
      saved_len <= '0;
`endif
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count_q   <= count_n;
      m_data_q  <= m_data_n;
      m_valid_q <= m_valid_n;
      m_last_q  <= m_last_n;
`ifdef RFD_REPLAY_EN
      saved_len <= saved_len_n;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_n   = state;
    wr_ptr_n  = wr_ptr;
    rd_ptr_n  = rd_ptr;
    count_n   = count_q;
    m_data_n  = m_data_q;
    m_valid_n = m_valid_q;
    m_last_n  = m_last_q;
`ifdef RFD_REPLAY_EN
    saved_len_n = saved_len;
`endif

    case (state)
      IDLE: begin
        // Flush with an empty buffer is ignored here.
        if (accept) begin
          wr_ptr_n = ADDR_WIDTH'(1);
          count_n  = CW'(1);
          state_n  = FILL;
`ifdef RFD_REPLAY_EN
          saved_len_n = '0;
`endif
        end else if (replay_go) begin
          rd_ptr_n = '0;
`ifdef RFD_REPLAY_EN
          count_n  = saved_len;
`endif
          state_n  = RD_ADDR;
        end
      end

      FILL: begin
        // A word accepted alongside flush is still written and drained.
        if (accept) begin
          wr_ptr_n = wr_ptr + ADDR_WIDTH'(1);
          count_n  = count_q + CW'(1);
          if ((count_q + CW'(1)) == CW'(DEPTH)) begin
            state_n = RD_ADDR;
          end
        end
        if (flush) begin
          state_n = RD_ADDR;
        end
      end

      RD_ADDR: begin
        state_n = RD_CAP;
      end

      RD_CAP: begin
        m_data_n  = ram_rdata;
        m_valid_n = 1'b1;
        m_last_n  = last_hit;
        state_n   = RD_HOLD;
      end

      RD_HOLD: begin
        if (m_valid_q && m_ready) begin
          m_valid_n = 1'b0;
          m_last_n  = 1'b0;
          if (m_last_q) begin
            count_n  = '0;
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            state_n  = IDLE;
`ifdef RFD_REPLAY_EN
            saved_len_n = count_q;
`endif
          end else begin
            rd_ptr_n = rd_ptr + ADDR_WIDTH'(1);
            state_n  = RD_ADDR;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_fill_drain_ctrl.sv
// Directed bench for ram_fill_drain_ctrl with a behavioural registered-address
// single-port RAM attached to the RAM pins.
module tb_ram_fill_drain_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       flush;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic [5:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic [6:0] count;
  logic       busy;
`ifdef RFD_REPLAY_EN
  logic       replay;
`endif

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  ram_fill_drain_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .flush     (flush),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .count     (count),
    .busy      (busy)
`ifdef RFD_REPLAY_EN
    ,
    .replay    (replay)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read address, q reflects the address of the previous edge
  logic [7:0] mem [64];
  logic [5:0] addr_q;
  always_ff @(posedge clk) begin
    addr_q <= ram_addr;
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end
  assign ram_rdata = mem[addr_q];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drain exp_q with m_ready high; optionally verify the input side stays stalled.
  task automatic drain(input bit stall);
    int n;
    int k;
    int cyc;
    n   = exp_q.size();
    k   = 0;
    cyc = 0;
    while (k < n && cyc < 4 * n + 10) begin
      #1;
      if (stall) begin
        chk("stall_s_ready", s_ready, 0);
        chk("stall_ram_we", ram_we, 0);
      end
      if (m_valid) begin
        chk("drain_data", m_data, exp_q[k]);
        chk("drain_last", m_last, (k == n - 1) ? 1 : 0);
        k++;
      end else begin
        chk("last_without_valid", m_last, 0);
      end
      @(negedge clk);
      cyc++;
    end
    if (k < n) chk("drain_timeout_words", k, n);
  endtask

  initial begin
    rst     = 1'b0;
    s_data  = '0;
    s_valid = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
`ifdef RFD_REPLAY_EN
    replay  = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    s_valid = 1'b1;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_ram_we", ram_we, 0);
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_s_ready", s_ready, 1);
    @(negedge clk);

    // Reset in the middle of a fill
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h50 + i);
      @(negedge clk);
    end
    chk("midfill_count", count, 3);
    #2 rst = 1'b0;
    #1;
    chk("midfill_rst_s_ready", s_ready, 0);
    chk("midfill_rst_ram_we", ram_we, 0);
    chk("midfill_rst_count", count, 0);
    chk("midfill_rst_m_valid", m_valid, 0);
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_count", count, 0);
    chk("post_rst_s_ready", s_ready, 1);
    chk("post_rst_busy", busy, 0);
    @(negedge clk);

    // Flush with nothing buffered is ignored
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("empty_flush_busy", busy, 0);

    // Full burst of 64 words with auto drain; input held valid during drain
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      exp_q.push_back(8'(i));
      #1;
      chk("full_s_ready", s_ready, 1);
      chk("full_wr_addr", ram_addr, i);
      @(negedge clk);
    end
    s_data  = 8'hEE;
    m_ready = 1'b1;
    chk("full_busy", busy, 1);
    chk("full_count", count, 64);
    drain(1'b1);
    // Back in IDLE: the stalled word is now accepted at address 0
    #1;
    chk("restart_s_ready", s_ready, 1);
    chk("restart_ram_we", ram_we, 1);
    chk("restart_addr", ram_addr, 0);
    @(negedge clk);
    s_valid = 1'b0;
    chk("restart_count", count, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'hEE);
    drain(1'b0);
    chk("single_done_count", count, 0);
    chk("single_done_busy", busy, 0);

    // Flush with the fifth word, then backpressure on the first output
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'hA0 + i);
      flush   = (i == 4);
      @(negedge clk);
    end
    s_valid = 1'b0;
    flush   = 1'b0;
    chk("flush_c1_m_valid", m_valid, 0);
    chk("flush_c1_busy", busy, 1);
    @(negedge clk);
    chk("flush_c2_m_valid", m_valid, 0);
    @(negedge clk);
    chk("flush_c3_m_valid", m_valid, 1);
    chk("flush_c3_m_data", m_data, 8'hA0);
    chk("flush_c3_m_last", m_last, 0);
    chk("flush_count", count, 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_m_valid", m_valid, 1);
      chk("bp_m_data", m_data, 8'hA0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("bp_after_m_valid", m_valid, 0);
    chk("bp_rd_ptr_plus1", ram_addr, 1);
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_m_valid", m_valid, 1);
    chk("bp_next_m_data", m_data, 8'hA1);
    m_ready = 1'b1;
    exp_q.delete();
    for (int i = 1; i < 5; i++) exp_q.push_back(8'(8'hA0 + i));
    drain(1'b0);
    chk("flush_done_count", count, 0);
    chk("flush_done_busy", busy, 0);

`ifdef RFD_REPLAY_EN
    // Burst of three, then replay it
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h11 * (i + 1));
      flush   = (i == 2);
      exp_q.push_back(8'(8'h11 * (i + 1)));
      @(negedge clk);
    end
    s_valid = 1'b0;
    flush   = 1'b0;
    drain(1'b0);
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    chk("replay_busy", busy, 1);
    chk("replay_count", count, 3);
    drain(1'b0);
    // Replay together with s_valid: the fill wins
    replay  = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h77;
    @(negedge clk);
    replay  = 1'b0;
    s_valid = 1'b0;
    chk("replay_vs_fill_busy", busy, 0);
    chk("replay_vs_fill_count", count, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h77);
    drain(1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
